// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - Fetch sequencer state encoding and reset/exception address defaults
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4,
      ST_ERROR  = 3'd5
   } pc_state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0040_0004;
   localparam logic [7:0]  TIMEOUT_DEF  = 8'd255;
   localparam logic [31:0] PC_STEP      = 32'd4;

   // Sequential successor; wraps modulo 2^32.
   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/pc_redir_sel.sv
// rtl/pc_redir_sel.sv - Same-cycle redirect priority: exception, eret, jump, branch
module pc_redir_sel
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
   input  logic        i_exc,
   input  logic        i_eret,
   input  logic [31:0] i_epc,
   input  logic        i_jmp_take,
   input  logic [31:0] i_jmp_target,
   input  logic        i_br_take,
   input  logic [31:0] i_br_target,
   output logic        o_any,
   output logic        o_trap,
   output logic [31:0] o_target
);

   always_comb begin
      o_target = i_br_target;
      if (i_exc) begin
         o_target = EXC_VEC;
      end else if (i_eret) begin
         o_target = i_epc;
      end else if (i_jmp_take) begin
         o_target = i_jmp_target;
      end
   end

   // Traps are the only redirects honoured while halted.
   assign o_trap = i_exc | i_eret;
   assign o_any  = o_trap | i_jmp_take | i_br_take;

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - Instruction fetch sequencer driving an external PC register
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
   parameter logic [7:0]  TIMEOUT  = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic        pc_ena,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        br_take,
   input  logic [31:0] br_target,
   input  logic        jmp_take,
   input  logic [31:0] jmp_target,
   input  logic        exc,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        halt,
   output logic        fetch_err
);

   pc_state_t   r_state;
   pc_state_t   w_state_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic [7:0]  w_cnt_inc;
   logic        r_pend;
   logic        w_pend_nxt;
   logic [31:0] r_redir_pc;
   logic [31:0] w_redir_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] r_pc_last;
   logic        w_load;
   logic [31:0] w_load_pc;
   logic        w_req;
   logic        w_valid;
   logic        w_any;
   logic        w_trap;
   logic [31:0] w_target;

   pc_redir_sel #(
      .EXC_VEC (EXC_VEC)
   ) u_redir_sel (
      .i_exc        (exc),
      .i_eret       (eret),
      .i_epc        (epc),
      .i_jmp_take   (jmp_take),
      .i_jmp_target (jmp_target),
      .i_br_take    (br_take),
      .i_br_target  (br_target),
      .o_any        (w_any),
      .o_trap       (w_trap),
      .o_target     (w_target)
   );

   assign w_cnt_inc = r_cnt + 8'd1;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_pend_nxt     = r_pend;
      w_redir_pc_nxt = r_redir_pc;
      w_instr_nxt    = r_instr;
      w_load         = 1'b0;
      w_load_pc      = r_pc_last;
      w_req          = 1'b0;
      w_valid        = 1'b0;
      // Any redirect not consumed by an accept is remembered; the latest one wins.
      if (w_any) begin
         w_pend_nxt     = 1'b1;
         w_redir_pc_nxt = w_target;
      end
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            w_req       = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            w_req = 1'b1;
            if (imem_ack) begin
               w_instr_nxt = imem_rdata;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_HOLD;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == TIMEOUT) begin
                  w_state_nxt = ST_ERROR;
               end
            end
         end
         ST_HOLD: begin
            w_valid = !r_pend;
            if (r_pend) begin
               w_load      = 1'b1;
               w_load_pc   = r_redir_pc;
               w_pend_nxt  = w_any;
               w_state_nxt = ST_REQ;
            end else if (instr_ready) begin
               w_load         = 1'b1;
               w_load_pc      = w_any ? w_target : pc_incr(pc_cur);
               w_pend_nxt     = 1'b0;
               w_redir_pc_nxt = r_redir_pc;
               w_state_nxt    = halt ? ST_HALTED : ST_REQ;
            end
         end
         ST_HALTED: begin
            w_pend_nxt     = r_pend;
            w_redir_pc_nxt = r_redir_pc;
            if (w_trap) begin
               w_load      = 1'b1;
               w_load_pc   = w_target;
               w_state_nxt = ST_REQ;
            end
         end
         default: begin
            w_pend_nxt     = r_pend;
            w_redir_pc_nxt = r_redir_pc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_pend     <= 1'b0;
         r_redir_pc <= '0;
         r_instr    <= '0;
         r_pc_last  <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pend     <= w_pend_nxt;
         r_redir_pc <= w_redir_pc_nxt;
         r_instr    <= w_instr_nxt;
         if (w_load) begin
            r_pc_last <= w_load_pc;
         end
      end
   end

   // pc_next holds the last loaded value between load pulses.
   assign pc_ena      = w_load;
   assign pc_next     = w_load_pc;
   assign imem_req    = w_req;
   assign imem_addr   = pc_cur;
   assign instr       = r_instr;
   assign instr_valid = w_valid;
   assign fetch_err   = (r_state == ST_ERROR);

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - Self-checking bench for the pc_seq fetch sequencer
module tb_pc_seq;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam logic [31:0] EXC_VEC  = 32'h0040_0004;

   logic        clk;
   logic        rst;
   logic [31:0] pc_cur;
   logic        pc_ena;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        br_take;
   logic [31:0] br_target;
   logic        jmp_take;
   logic [31:0] jmp_target;
   logic        exc;
   logic        eret;
   logic [31:0] epc;
   logic        halt;
   logic        fetch_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        exc;
      logic        eret;
      logic        jmp;
      logic        br;
      logic [31:0] epc_v;
      logic [31:0] jmp_t;
      logic [31:0] br_t;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[9];

   pc_seq #(
      .RESET_PC (RESET_PC),
      .EXC_VEC  (EXC_VEC),
      .TIMEOUT  (8'd255)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_cur      (pc_cur),
      .pc_ena      (pc_ena),
      .pc_next     (pc_next),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .br_take     (br_take),
      .br_target   (br_target),
      .jmp_take    (jmp_take),
      .jmp_target  (jmp_target),
      .exc         (exc),
      .eret        (eret),
      .epc         (epc),
      .halt        (halt),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External PC register that the sequencer steers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_cur <= RESET_PC;
      else if (pc_ena) pc_cur <= pc_next;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic clr();
      exc = 1'b0; eret = 1'b0; jmp_take = 1'b0; br_take = 1'b0;
      halt = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
   endtask

   function automatic vec_t mk(input int lat, input logic [31:0] rd, input logic [3:0] sel,
                               input logic [31:0] ep, input logic [31:0] jt,
                               input logic [31:0] bt, input logic [31:0] ex);
      vec_t v;
      v.lat = lat; v.rdata = rd;
      v.exc = sel[3]; v.eret = sel[2]; v.jmp = sel[1]; v.br = sel[0];
      v.epc_v = ep; v.jmp_t = jt; v.br_t = bt; v.exp_pc = ex;
      return v;
   endfunction

   function automatic logic [31:0] model_prio(input logic e, input logic er, input logic j,
                                              input logic [31:0] ep, input logic [31:0] jt,
                                              input logic [31:0] bt);
      if (e) return EXC_VEC;
      if (er) return ep;
      if (j) return jt;
      return bt;
   endfunction

   task automatic reset_dut(input bit hold_ack);
      clr();
      if (hold_ack) begin
         imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      end
      rst = 1'b0;
      #1;
      chk1("rst_valid", instr_valid, 1'b0);
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_ena", pc_ena, 1'b0);
      chk32("rst_next", pc_next, RESET_PC);
      chk1("rst_err", fetch_err, 1'b0);
      chk32("rst_instr", instr, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk1("idle_req", imem_req, 1'b0);
      chk32("idle_instr", instr, 32'h0);
      imem_ack = 1'b0;
      tick();
      chk1("first_req", imem_req, 1'b1);
      chk32("first_addr", imem_addr, RESET_PC);
   endtask

   task automatic wait_req(input string nm);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk1(nm, imem_req, 1'b1);
   endtask

   // Ack arrives on the lat-th cycle of the request, counting the REQ cycle as the first.
   task automatic do_fetch(input string nm, input int lat, input logic [31:0] data,
                           output logic [31:0] addr);
      wait_req(nm);
      addr = imem_addr;
      for (int k = 1; k < lat; k++) tick();
      imem_ack = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
   endtask

   task automatic rnd_redir(output logic any, output logic [31:0] tgt);
      exc = 1'b0; eret = 1'b0; jmp_take = 1'b0; br_take = 1'b0;
      any = 1'b0;
      tgt = 32'h0;
      if ($urandom_range(0, 4) == 0) begin
         exc        = ($urandom_range(0, 3) == 0);
         eret       = ($urandom_range(0, 2) == 0);
         jmp_take   = ($urandom_range(0, 1) == 1);
         br_take    = ($urandom_range(0, 1) == 1);
         epc        = $urandom & 32'hFFFF_FFFC;
         jmp_target = $urandom & 32'hFFFF_FFFC;
         br_target  = $urandom & 32'hFFFF_FFFC;
         any = exc | eret | jmp_take | br_take;
         tgt = model_prio(exc, eret, jmp_take, epc, jmp_target, br_target);
      end
   endtask

   initial begin
      logic [31:0] addr;
      logic [31:0] exp_prev;
      logic [31:0] m_pc;
      logic [31:0] m_tgt;
      logic [31:0] nxt;
      logic [31:0] data;
      logic        m_sq;
      logic        any;
      logic [31:0] tgt;
      int          lat;
      int          stall;
      bit          done;

      tbl[0] = mk(2, 32'h2008_0001, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0040_0004);
      tbl[1] = mk(3, 32'h8C01_0004, 4'b0001, 32'h0,         32'h0,         32'h0040_0100, 32'h0040_0100);
      tbl[2] = mk(2, 32'h0000_0000, 4'b0011, 32'h0,         32'h0040_0200, 32'h0040_0100, 32'h0040_0200);
      tbl[3] = mk(4, 32'h3C01_ABCD, 4'b0111, 32'h0040_0040, 32'h0040_0200, 32'h0040_0100, 32'h0040_0040);
      tbl[4] = mk(2, 32'hFFFF_FFFF, 4'b1111, 32'h0040_0040, 32'h0040_0200, 32'h0040_0100, 32'h0040_0004);
      tbl[5] = mk(3, 32'h1234_5678, 4'b0010, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC);
      tbl[6] = mk(2, 32'h0BAD_F00D, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0000_0000);
      tbl[7] = mk(5, 32'h1111_1111, 4'b0101, 32'h0040_0010, 32'h0,         32'h0040_0100, 32'h0040_0010);
      tbl[8] = mk(2, 32'h2222_2222, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0040_0014);

      rst = 1'b1;
      clr();
      imem_rdata = 32'h0; br_target = 32'h0; jmp_target = 32'h0; epc = 32'h0;
      tick();
      reset_dut(1'b0);

      // Accept-cycle redirect priority, sequential step and address wrap.
      exp_prev = RESET_PC;
      for (int i = 0; i < 9; i++) begin
         do_fetch($sformatf("tbl_req_%0d", i), tbl[i].lat, tbl[i].rdata, addr);
         chk32($sformatf("tbl_addr_%0d", i), addr, exp_prev);
         exc = tbl[i].exc; eret = tbl[i].eret; jmp_take = tbl[i].jmp; br_take = tbl[i].br;
         epc = tbl[i].epc_v; jmp_target = tbl[i].jmp_t; br_target = tbl[i].br_t;
         instr_ready = 1'b1;
         #1;
         chk1($sformatf("tbl_valid_%0d", i), instr_valid, 1'b1);
         chk32($sformatf("tbl_instr_%0d", i), instr, tbl[i].rdata);
         chk1($sformatf("tbl_ena_%0d", i), pc_ena, 1'b1);
         chk32($sformatf("tbl_next_%0d", i), pc_next, tbl[i].exp_pc);
         tick();
         clr();
         #1;
         chk1($sformatf("tbl_ena_pulse_%0d", i), pc_ena, 1'b0);
         chk1($sformatf("tbl_valid_drop_%0d", i), instr_valid, 1'b0);
         exp_prev = tbl[i].exp_pc;
      end

      // Decode back-pressure for five cycles, then a single accept.
      do_fetch("stall_req", 3, 32'hCAFE_0024, addr);
      chk32("stall_addr", addr, 32'h0040_0014);
      for (int k = 0; k < 5; k++) begin
         instr_ready = 1'b0;
         #1;
         chk1("stall_valid", instr_valid, 1'b1);
         chk32("stall_instr", instr, 32'hCAFE_0024);
         chk1("stall_ena", pc_ena, 1'b0);
         tick();
      end
      instr_ready = 1'b1;
      #1;
      chk1("stall_accept_ena", pc_ena, 1'b1);
      chk32("stall_accept_next", pc_next, 32'h0040_0018);
      tick();
      clr();
      #1;
      chk1("stall_ena_pulse", pc_ena, 1'b0);

      // Exception during WAIT squashes the word that is still in flight.
      wait_req("exc_req");
      chk32("exc_addr", imem_addr, 32'h0040_0018);
      tick();
      exc = 1'b1;
      #1;
      chk1("exc_wait_ena", pc_ena, 1'b0);
      tick();
      clr();
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
      tick();
      clr();
      instr_ready = 1'b1;
      #1;
      chk1("exc_squash_valid", instr_valid, 1'b0);
      chk1("exc_squash_ena", pc_ena, 1'b1);
      chk32("exc_squash_next", pc_next, 32'h0040_0004);
      tick();
      clr();
      #1;
      chk1("exc_refetch_req", imem_req, 1'b1);
      chk32("exc_refetch_addr", imem_addr, 32'h0040_0004);

      // Halt at accept, ignore non-trap inputs, resume on eret.
      do_fetch("halt_req", 2, 32'h0000_000C, addr);
      chk32("halt_addr", addr, 32'h0040_0004);
      halt = 1'b1; instr_ready = 1'b1;
      #1;
      chk1("halt_valid", instr_valid, 1'b1);
      chk1("halt_ena", pc_ena, 1'b1);
      chk32("halt_next", pc_next, 32'h0040_0008);
      tick();
      clr();
      for (int k = 0; k < 4; k++) begin
         br_take = 1'b1; br_target = 32'h0050_0000;
         jmp_take = 1'b1; jmp_target = 32'h0060_0000;
         imem_ack = 1'b1; instr_ready = 1'b1; halt = 1'b1;
         #1;
         chk1("halted_req", imem_req, 1'b0);
         chk1("halted_valid", instr_valid, 1'b0);
         chk1("halted_ena", pc_ena, 1'b0);
         tick();
         clr();
      end
      eret = 1'b1; epc = 32'h0040_0040; br_take = 1'b1;
      #1;
      chk1("resume_ena", pc_ena, 1'b1);
      chk32("resume_next", pc_next, 32'h0040_0040);
      tick();
      clr();
      #1;
      chk1("resume_req", imem_req, 1'b1);
      chk32("resume_addr", imem_addr, 32'h0040_0040);
      do_fetch("resume_fetch", 2, 32'h0000_0040, addr);
      instr_ready = 1'b1;
      #1;
      chk1("resume_valid", instr_valid, 1'b1);
      chk32("resume_accept_next", pc_next, 32'h0040_0044);
      tick();
      clr();

      // Fetch timeout: 255 WAIT cycles without ack.
      wait_req("to_req");
      chk32("to_addr", imem_addr, 32'h0040_0044);
      tick();
      for (int k = 0; k < 254; k++) tick();
      chk1("to_last_wait_req", imem_req, 1'b1);
      chk1("to_last_wait_err", fetch_err, 1'b0);
      tick();
      chk1("to_err", fetch_err, 1'b1);
      chk1("to_req_off", imem_req, 1'b0);
      for (int k = 0; k < 3; k++) begin
         imem_ack = 1'b1; exc = 1'b1; eret = 1'b1; instr_ready = 1'b1;
         #1;
         chk1("err_sticky", fetch_err, 1'b1);
         chk1("err_req", imem_req, 1'b0);
         chk1("err_ena", pc_ena, 1'b0);
         tick();
         clr();
      end
      reset_dut(1'b1);

      // Randomized transactions against a fetch-level reference model.
      m_pc = RESET_PC;
      m_sq = 1'b0;
      m_tgt = 32'h0;
      for (int t = 0; t < 60; t++) begin
         lat = $urandom_range(2, 5);
         data = $urandom;
         for (int c = 1; c <= lat; c++) begin
            rnd_redir(any, tgt);
            if (c == lat) begin
               imem_ack = 1'b1; imem_rdata = data;
            end
            #1;
            chk1("rnd_req", imem_req, 1'b1);
            chk32("rnd_addr", imem_addr, m_pc);
            chk1("rnd_fetch_ena", pc_ena, 1'b0);
            if (any) begin
               m_sq = 1'b1; m_tgt = tgt;
            end
            tick();
            clr();
         end
         done = 1'b0;
         stall = 0;
         while (!done) begin
            rnd_redir(any, tgt);
            instr_ready = ($urandom_range(0, 1) == 1) || (stall >= 4);
            #1;
            chk1("rnd_valid", instr_valid, !m_sq);
            if (m_sq) begin
               chk1("rnd_squash_ena", pc_ena, 1'b1);
               chk32("rnd_squash_next", pc_next, m_tgt);
               m_pc = m_tgt;
               m_sq = any;
               if (any) m_tgt = tgt;
               done = 1'b1;
            end else if (instr_ready) begin
               nxt = any ? tgt : m_pc + 32'd4;
               chk32("rnd_instr", instr, data);
               chk1("rnd_accept_ena", pc_ena, 1'b1);
               chk32("rnd_accept_next", pc_next, nxt);
               m_pc = nxt;
               done = 1'b1;
            end else begin
               chk32("rnd_hold_instr", instr, data);
               chk1("rnd_hold_ena", pc_ena, 1'b0);
               if (any) begin
                  m_sq = 1'b1; m_tgt = tgt;
               end
               stall++;
            end
            tick();
            clr();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
